// File: rtl/adc_pkg.sv
// Shared types and frame constants for the MCP3202-style ADC sampling controller.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    SHIFT  = 2'd2,
    CSHOLD = 2'd3
  } adc_state_t;

  localparam int FRAME_LEN = 17;
  localparam int CMD_BITS  = 4;
  localparam int NULL_POS  = 4;
  localparam int SAMPLE_W  = 12;
  localparam int RX_W      = FRAME_LEN - NULL_POS;

  // Bit 0 is the start bit and goes out first; MSBF is the last command bit sent.
  function automatic logic [CMD_BITS-1:0] cmd_word(input logic msbf,
                                                   input logic odd,
                                                   input logic sgl);
    return {msbf, odd, sgl, 1'b1};
  endfunction

endpackage

// File: rtl/half_period_timer.sv
// Loadable down-counter that ticks once every HALF enabled cycles; paces adc_sck phases.
module half_period_timer #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam logic [3:0] RELOAD = 4'(HALF - 1);

  logic [3:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == 4'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (load || tick) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_sample_ctrl.sv
// SPI master running one 17-period MCP3202 conversion frame per start request and
// presenting the 12-bit result with a one-cycle valid strobe.
//
// state  | meaning
// IDLE   | chip_en high, waiting for start
// SETUP  | chip_en low, start bit on adc_sdo, adc_sck held low before the first rise
// SHIFT  | 17 adc_sck periods; command out, null + 12 data bits in
// CSHOLD | chip_en high again, sample published, minimum deselect time
module adc_sample_ctrl
  import adc_pkg::*;
#(
  parameter int HALF       = 2,
  parameter int CSH_CYCLES = 2,
  parameter int MSBF       = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                channel,
  input  logic                single_ended,
  input  logic                clr_overrun,
  input  logic                adc_sdi,
  output logic                adc_sdo,
  output logic                adc_sck,
  output logic                chip_en,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int CSH_W = (CSH_CYCLES > 1) ? $clog2(CSH_CYCLES) : 1;
  localparam logic [CSH_W-1:0] CSH_LOAD = CSH_W'(CSH_CYCLES - 1);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_LEN - 1);
  localparam logic [4:0] LAST_CMD = 5'(CMD_BITS - 1);

  adc_state_t state_q, state_d;

  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic [4:0]          bit_q, bit_d;
  logic [RX_W-1:0]     rx_q, rx_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [CSH_W-1:0]    csh_q, csh_d;
  logic                valid_q, valid_d;
  logic                sck_q, sck_d;
  logic                sdo_q, sdo_d;
  logic                cs_q, cs_d;
  logic                ovr_q, ovr_d;
  logic                first_q, first_d;

  logic tmr_load, tmr_en, tmr_tick;

  // The first SETUP cycle holds the timer, giving the 1 + 35*HALF start-to-valid latency.
  assign tmr_load = (state_q == IDLE);
  assign tmr_en   = ((state_q == SETUP) && !first_q) || (state_q == SHIFT);

  half_period_timer #(
    .HALF(HALF)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (tmr_load),
    .en   (tmr_en),
    .tick (tmr_tick)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    bit_d    = bit_q;
    rx_d     = rx_q;
    sample_d = sample_q;
    csh_d    = csh_q;
    valid_d  = 1'b0;
    sck_d    = sck_q;
    sdo_d    = sdo_q;
    cs_d     = cs_q;
    ovr_d    = ovr_q;
    first_d  = 1'b0;

    if (start && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        bit_d = 5'd0;
        if (start) begin
          cmd_d   = cmd_word(1'(MSBF), channel, single_ended);
          rx_d    = '0;
          cs_d    = 1'b0;
          sdo_d   = 1'b1;
          first_d = 1'b1;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (tmr_tick) begin
          sck_d   = 1'b1;
          bit_d   = 5'd0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (tmr_tick) begin
          if (sck_q) begin
            // Falling edge: capture MISO and present the next command bit.
            sck_d = 1'b0;
            rx_d  = RX_W'({rx_q, adc_sdi});
            if (bit_q < LAST_CMD) begin
              sdo_d = cmd_q[bit_q[1:0] + 2'd1];
            end else begin
              sdo_d = 1'b0;
            end
          end else if (bit_q == LAST_BIT) begin
            cs_d     = 1'b1;
            sample_d = rx_q[SAMPLE_W-1:0];
            valid_d  = 1'b1;
            csh_d    = CSH_LOAD;
            state_d  = CSHOLD;
          end else begin
            bit_d = bit_q + 5'd1;
            sck_d = 1'b1;
          end
        end
      end

      CSHOLD: begin
        if (csh_q == '0) begin
          bit_d   = 5'd0;
          state_d = IDLE;
        end else begin
          csh_d = csh_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      bit_q    <= '0;
      rx_q     <= '0;
      sample_q <= '0;
      csh_q    <= '0;
      valid_q  <= 1'b0;
      sck_q    <= 1'b0;
      sdo_q    <= 1'b0;
      cs_q     <= 1'b1;
      ovr_q    <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      bit_q    <= bit_d;
      rx_q     <= rx_d;
      sample_q <= sample_d;
      csh_q    <= csh_d;
      valid_q  <= valid_d;
      sck_q    <= sck_d;
      sdo_q    <= sdo_d;
      cs_q     <= cs_d;
      ovr_q    <= ovr_d;
      first_q  <= first_d;
    end
  end

  assign adc_sdo      = sdo_q;
  assign adc_sck      = sck_q;
  assign chip_en      = cs_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl: HALF=2 and HALF=1 instances, each with a simple ADC model.
module tb_adc_sample_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic channel = 1'b0, single_ended = 1'b0, clr_overrun = 1'b0;
  logic sdi0 = 1'b0, sdi1 = 1'b0;

  logic sdo0, sck0, cs0, valid0, busy0, ovr0;
  logic sdo1, sck1, cs1, valid1, busy1, ovr1;
  logic [11:0] sample0, sample1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  adc_sample_ctrl #(.HALF(2), .CSH_CYCLES(2), .MSBF(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .channel(channel),
    .single_ended(single_ended), .clr_overrun(clr_overrun), .adc_sdi(sdi0),
    .adc_sdo(sdo0), .adc_sck(sck0), .chip_en(cs0), .sample(sample0),
    .sample_valid(valid0), .busy(busy0), .overrun(ovr0)
  );

  adc_sample_ctrl #(.HALF(1), .CSH_CYCLES(2), .MSBF(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .channel(channel),
    .single_ended(single_ended), .clr_overrun(clr_overrun), .adc_sdi(sdi1),
    .adc_sdo(sdo1), .adc_sck(sck1), .chip_en(cs1), .sample(sample1),
    .sample_valid(valid1), .busy(busy1), .overrun(ovr1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: drives the bit for period k right after the k-th rise; the null bit is
  // deliberately 1 so a controller that keeps it would corrupt the sample.
  function automatic logic model_bit(input logic [11:0] w, input int k);
    if (k >= 5 && k <= 16) return w[16-k];
    return 1'b1;
  endfunction

  logic [11:0] word0 = 12'h0, word1 = 12'h0;
  logic [3:0]  sdo_bits0 = 4'h0, sdo_bits1 = 4'h0;
  int rise0 = 0, rise1 = 0, t_r1 = 0, t_r2 = 0;
  logic psck0 = 1'b0, pcs0 = 1'b1, psck1 = 1'b0, pcs1 = 1'b1;

  always @(negedge clk) begin
    if (pcs0 && !cs0) rise0 = 0;
    if (!cs0 && sck0 && !psck0) begin
      if (rise0 < 4) sdo_bits0[rise0] = sdo0;
      sdi0 = model_bit(word0, rise0);
      rise0 = rise0 + 1;
    end
    psck0 = sck0;
    pcs0  = cs0;
  end

  always @(negedge clk) begin
    if (pcs1 && !cs1) rise1 = 0;
    if (!cs1 && sck1 && !psck1) begin
      if (rise1 < 4) sdo_bits1[rise1] = sdo1;
      if (rise1 == 0) t_r1 = cyc;
      if (rise1 == 1) t_r2 = cyc;
      sdi1 = model_bit(word1, rise1);
      rise1 = rise1 + 1;
    end
    psck1 = sck1;
    pcs1  = cs1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Pulses start for one edge, optionally flips the command inputs mid-frame,
  // and returns the number of edges until sample_valid.
  task automatic run_frame(input int d, input logic [11:0] w, input bit flip, output int lat);
    bit found;
    if (d == 0) word0 = w; else word1 = w;
    @(negedge clk);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    chk("busy_rise", 32'(d == 0 ? busy0 : busy1), 32'd1);
    if (flip) begin
      channel      = ~channel;
      single_ended = ~single_ended;
    end
    lat = 0;
    found = 1'b0;
    repeat (300) begin
      @(posedge clk);
      #1;
      lat++;
      if ((d == 0) ? valid0 : valid1) begin
        found = 1'b1;
        break;
      end
    end
    chk("valid_timeout", 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input int d, output int n);
    bit done;
    n = 0;
    done = 1'b0;
    repeat (200) begin
      @(posedge clk);
      #1;
      n++;
      if (!((d == 0) ? busy0 : busy1)) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, n, nvalid, bad, gap, maxgap;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_chip_en", 32'(cs0), 32'd1);
    chk("rst_sck", 32'(sck0), 32'd0);
    chk("rst_sdo", 32'(sdo0), 32'd0);
    chk("rst_sample", 32'(sample0), 32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_overrun", 32'(ovr0), 32'd0);
    chk("rst_h1_idle", 32'({cs1, sck1, busy1, ovr1}), 32'b1000);
    @(negedge clk);
    reset = 1'b1;

    // Single frame, single-ended channel 0.
    single_ended = 1'b1;
    channel      = 1'b0;
    run_frame(0, 12'hA5C, 1'b0, lat);
    chk("f1_latency", 32'(lat), 32'd71);
    chk("f1_sample", 32'(sample0), 32'hA5C);
    chk("f1_cs_at_valid", 32'({cs0, busy0}), 32'b11);
    chk("f1_cmd_bits", 32'(sdo_bits0), 32'b1011);
    chk("f1_rises", 32'(rise0), 32'd17);
    @(posedge clk);
    #1;
    chk("f1_valid_width", 32'(valid0), 32'd0);
    wait_idle(0, n);
    chk("f1_cshold_len", 32'(n), 32'd1);

    // Differential channel 1; second frame flips inputs mid-frame to prove latching.
    single_ended = 1'b0;
    channel      = 1'b1;
    run_frame(0, 12'h001, 1'b0, lat);
    chk("f2_sample", 32'(sample0), 32'h001);
    chk("f2_cmd_bits", 32'(sdo_bits0), 32'b1101);
    wait_idle(0, n);
    run_frame(0, 12'hFFF, 1'b1, lat);
    chk("f3_sample", 32'(sample0), 32'hFFF);
    chk("f3_cmd_latched", 32'(sdo_bits0), 32'b1101);
    wait_idle(0, n);

    // start held high for 300 cycles.
    word0 = 12'h5A3;
    @(negedge clk);
    start0 = 1'b1;
    nvalid = 0;
    bad = 0;
    gap = 0;
    maxgap = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (valid0) begin
        nvalid++;
        if (sample0 != 12'h5A3) bad++;
      end
      if (cs0) begin
        gap++;
      end else begin
        if (gap > maxgap) maxgap = gap;
        gap = 0;
      end
    end
    start0 = 1'b0;
    chk("cont_frames", 32'(nvalid), 32'd4);
    chk("cont_bad_samples", 32'(bad), 32'd0);
    chk("cont_max_gap", 32'(maxgap), 32'd3);
    chk("cont_overrun", 32'(ovr0), 32'd1);
    wait_idle(0, n);
    chk("cont_overrun_sticky", 32'(ovr0), 32'd1);
    @(negedge clk);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    chk("clr_overrun", 32'(ovr0), 32'd0);

    // Reset during period k=8.
    word0 = 12'h3C6;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    n = 0;
    while (rise0 < 9 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("k8_reached", 32'(rise0 >= 9), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_state", 32'({cs0, sck0, busy0, valid0}), 32'b1000);
    chk("abort_sample", 32'(sample0), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_frame(0, 12'h3C6, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd71);
    chk("post_rst_sample", 32'(sample0), 32'h3C6);
    wait_idle(0, n);

    // start and clr_overrun together during SHIFT.
    word0 = 12'h6E1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    start0 = 1'b1;
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    clr_overrun = 1'b0;
    chk("set_beats_clear", 32'(ovr0), 32'd1);
    wait_idle(0, n);
    chk("dropped_start_sample", 32'(sample0), 32'h6E1);

    // HALF=1 instance.
    single_ended = 1'b1;
    channel      = 1'b0;
    run_frame(1, 12'h800, 1'b0, lat);
    chk("h1_latency", 32'(lat), 32'd36);
    chk("h1_sample", 32'(sample1), 32'h800);
    chk("h1_sck_period", 32'(t_r2 - t_r1), 32'd2);
    chk("h1_rises", 32'(rise1), 32'd17);
    chk("h1_cmd_bits", 32'(sdo_bits1), 32'b1011);
    wait_idle(1, n);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

SPI master that runs one MCP3202-style 12-bit conversion frame per `start` pulse and presents the result as a parallel sample with a one-cycle valid strobe. It sits directly upstream of the sample memory write path: `start` comes from the sample-rate divider, and `sample`/`sample_valid` drive the zero-extended memory write data and the write enable. All logic runs in the `fpga_sck` domain, connected here as `clk`.

## Interface
Parameters:
- `HALF`, default 2: `clk` cycles per `adc_sck` half-period. Legal range is 1..15.
- `CSH_CYCLES`, default 2: minimum number of `clk` cycles `chip_en` stays high after a frame, before the next frame may start.
- `MSBF`, default 1: value sent in the MSBF command bit.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock. All flops are rising-edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: request a conversion. Sampled only in IDLE.
- `channel` in 1: ODD/SIGN command bit. Latched when a frame starts.
- `single_ended` in 1: SGL/DIFF command bit. Latched when a frame starts.
- `clr_overrun` in 1: clears `overrun`.
- `adc_sdi` in 1: serial data from the ADC (MISO).
- `adc_sdo` out 1: serial data to the ADC (MOSI).
- `adc_sck` out 1: serial clock to the ADC. Idles low (SPI mode 0,0).
- `chip_en` out 1: ADC chip select, active-low.
- `sample` out 12: last converted result.
- `sample_valid` out 1: one-cycle strobe, asserted when `sample` updates.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: sticky flag, set when `start` arrives while `busy`.

## Operation
- **Reset** (`reset`=0 at a rising edge):
  - Go to IDLE.
  - `chip_en`=1, `adc_sck`=0, `adc_sdo`=0, `sample`=0, `sample_valid`=0, `busy`=0, `overrun`=0.
  - A reset during a frame aborts the frame with no `sample_valid`.
- **States:** IDLE → SETUP → SHIFT → CSHOLD → IDLE.
- **IDLE:**
  - If `start`=1: latch the command word {1, `single_ended`, `channel`, `MSBF`}.
  - Next cycle: `chip_en`=0, `adc_sdo`=command bit 0 (start bit = 1), state SETUP.
- **SETUP:** hold `adc_sck`=0 for `HALF` cycles, then go to SHIFT with period index k=0.
- **SHIFT:** 17 `adc_sck` periods, k=0..16. Each period is `HALF` cycles with `adc_sck`=1, then `HALF` cycles with `adc_sck`=0.
  - At the clock edge ending the high phase of period k, `adc_sdi` is shifted into the receive register. This edge is also the `adc_sck` falling edge.
  - At that same edge, `adc_sdo` updates to command bit k+1 for k=0..2. For k≥3 it updates to 0.
  - Period k=4 captures the null bit, which is discarded.
  - Periods k=5..16 capture B11..B0, MSB first.
  - After the low phase of k=16, go to CSHOLD.
- **CSHOLD:**
  - On entry: `chip_en`=1, `sample` loads the 12 captured bits, `sample_valid`=1 for exactly that cycle.
  - Stay in CSHOLD for `CSH_CYCLES` cycles total, then go to IDLE.
- **Start handling:**
  - `start` outside IDLE is dropped, not queued, and sets `overrun`.
  - `overrun` set and `clr_overrun` in the same cycle: set wins.
- **Latching:** `channel` and `single_ended` are not re-sampled during a frame.

## Timing
- Latency: `sample_valid` rises 1 + HALF×35 cycles after the edge that samples `start` (71 cycles at HALF=2).
- Frame occupancy: 1 + HALF×35 + CSH_CYCLES cycles from `start` accepted to IDLE (73 at defaults).
  - A back-to-back `start` is accepted on the first IDLE cycle.
- Outputs:
  - `chip_en`, `adc_sck` and `adc_sdo` are registered and change only on `clk` edges.
  - `adc_sdo` is stable for at least `HALF` cycles before each `adc_sck` rise.
- `busy` and `chip_en`:
  - `busy` rises in the cycle after `start` is accepted.
  - `busy` is low in the cycle after CSHOLD ends.
  - `busy` does not track `chip_en`: it stays high through CSHOLD while `chip_en` is already 1.
- Counters and widths:
  - Half-period counter: 4 bits. Terminal count is HALF−1.
  - Bit counter k: 5 bits. It never exceeds 16 and is cleared on IDLE.
  - Receive register: 13 bits (null + 12 data). The top bit is dropped on load.

## Structure
- Package `adc_pkg`:
  - State enum `adc_state_t` {IDLE, SETUP, SHIFT, CSHOLD}.
  - Constants FRAME_LEN=17, CMD_BITS=4, NULL_POS=4, SAMPLE_W=12.
- Sub-module `half_period_timer`:
  - Loadable down-counter producing a `tick` every `HALF` cycles while enabled.
  - Drives the `adc_sck` toggle and the phase advance.
  - FSM, shift registers and flags live in `adc_sample_ctrl`.

## Test plan
- Single frame, defaults, `single_ended`=1, `channel`=0, ADC model returns 0xA5C:
  - → `adc_sdo` bits on the first 4 rises are 1,1,0,1.
  - → `sample`=0xA5C with `sample_valid` high one cycle at start+71.
  - → exactly 17 `adc_sck` rises while `chip_en`=0.
- `channel`=1, `single_ended`=0, model returns 0x001 then 0xFFF on consecutive frames:
  - → command bits 1,0,1,1.
  - → samples 0x001 then 0xFFF.
  - → second `chip_en` fall no earlier than 2 cycles after the first rise.
- `start` held high continuously for 300 cycles:
  - → 4 complete frames (300/73), no gap beyond CSH_CYCLES+1.
  - → `overrun`=1.
  - → `clr_overrun` pulse in IDLE clears it.
- `reset`=0 asserted at k=8:
  - → next cycle `chip_en`=1, `adc_sck`=0, `busy`=0, `sample`=0, no `sample_valid`.
  - → a subsequent `start` runs a clean full frame.
- HALF=1 build:
  - → `sample_valid` at start+36.
  - → `adc_sck` period 2 cycles.
  - → data captured correctly for 0x800.
- `start` and `clr_overrun` both high during SHIFT:
  - → `overrun`=1.
